// File: rtl/inst_mem_loader.sv
// inst_mem_loader: instruction memory with a byte-stream program loader that stalls fetch and holds the CPU in reset while loading.
module inst_mem_loader #(
  parameter int CPU_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CPU_WIDTH-1:0]  inst_addr,
  output logic [CPU_WIDTH-1:0]  inst_data,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  cpu_rst_n
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [1:0] {RUN, LOAD_LO, LOAD_HI, FLUSH} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [7:0]            lo_q, lo_d;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d, cpu_rst_n_q, cpu_rst_n_d;
  logic [CPU_WIDTH-1:0]  mem [DEPTH];
  logic accept, last, start, wr_en, unused_addr;
  assign accept = load_valid & ready_q;
  assign last = {1'b0, ptr_q} == len_q - 1'b1;
  assign start = (state_q == RUN) & load_start;
  // the reset gate keeps a high byte arriving on a reset edge from landing in memory
  assign wr_en = rst_n & accept & (state_q == LOAD_HI);
  assign unused_addr = ^inst_addr[CPU_WIDTH-1:ADDR_WIDTH];
  always_comb begin
    state_d = state_q == RUN     ? (load_start ? LOAD_LO : RUN) :
              state_q == LOAD_LO ? (accept ? LOAD_HI : LOAD_LO) :
              state_q == LOAD_HI ? (accept ? (last ? FLUSH : LOAD_LO) : LOAD_HI) : RUN;
    ptr_d = start ? '0 : (state_q == LOAD_HI && accept && !last) ? ptr_q + 1'b1 : ptr_q;
    len_d = start ? (load_len == '0 ? (ADDR_WIDTH+1)'(DEPTH) : {1'b0, load_len}) : len_q;
    lo_d = (state_q == LOAD_LO && accept) ? load_byte : lo_q;
    ready_d = state_d == LOAD_LO || state_d == LOAD_HI;
    busy_d = state_d != RUN;
    done_d = state_d == FLUSH;
    cpu_rst_n_d = state_d == RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      ptr_q <= '0;
      len_q <= '0;
      lo_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cpu_rst_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      len_q <= len_d;
      lo_q <= lo_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q] <= CPU_WIDTH'({load_byte, lo_q});
  end
  assign inst_data = state_q == RUN ? mem[inst_addr[ADDR_WIDTH-1:0]] : '0;
  assign load_ready = ready_q;
  assign load_busy = busy_q;
  assign load_done = done_q;
  assign cpu_rst_n = cpu_rst_n_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: randomized scenarios for inst_mem_loader checked against a word-array model of the memory image.
module tb_inst_mem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] inst_addr = '0;
  logic [15:0] inst_data;
  logic        load_start = 1'b0;
  logic [9:0]  load_len = '0;
  logic [7:0]  load_byte = '0;
  logic        load_valid = 1'b0;
  logic        load_ready, load_busy, load_done, cpu_rst_n;
  int checks = 0, fails = 0, mask_err = 0, done_cnt = 0;
  logic [15:0] model_mem [1024];
  logic [15:0] img [$];

  inst_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr), .inst_data(inst_data),
    .load_start(load_start), .load_len(load_len), .load_byte(load_byte),
    .load_valid(load_valid), .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  // fetch must see zeros, the CPU must be held in reset, and no byte may be accepted in FLUSH while busy
  always @(negedge clk) begin
    if (load_busy && inst_data !== 16'h0) mask_err++;
    if (load_done && load_ready) mask_err++;
    if (load_busy === cpu_rst_n) mask_err++;
    if (load_done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_read(input logic [15:0] addr, input string name);
    inst_addr = addr;
    #1;
    checks++;
    if (inst_data !== model_mem[addr[9:0]]) begin
      fails++;
      $display("FAIL %s addr=%h: got %h expected %h", name, addr, inst_data, model_mem[addr[9:0]]);
    end
  endtask

  task automatic run_load(input int len, input int max_gap, input bit spam, input string name);
    int d0, nwords;
    logic [7:0] b;
    nwords = (len == 0) ? 1024 : len;
    mask_err = 0;
    d0 = done_cnt;
    inst_addr = '0;
    load_start = 1'b1;
    load_len = 10'(len);
    cyc();
    load_start = 1'b0;
    checks++;
    if (load_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
      fails++;
      $display("FAIL %s start: ready=%b cpu_rst_n=%b expected 1/0", name, load_ready, cpu_rst_n);
    end
    for (int i = 0; i < 2 * nwords; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        load_valid = 1'b0;
        load_start = spam && ($urandom % 2 == 1);
        load_len = 10'($urandom);
        cyc();
      end
      load_start = 1'b0;
      b = (i % 2 == 1) ? img[i/2][15:8] : img[i/2][7:0];
      load_valid = 1'b1;
      load_byte = b;
      cyc();
      load_valid = 1'b0;
    end
    checks++;
    if (load_done !== 1'b1 || load_ready !== 1'b0 || cpu_rst_n !== 1'b0 || load_busy !== 1'b1) begin
      fails++;
      $display("FAIL %s flush: done=%b ready=%b cpu_rst_n=%b busy=%b expected 1/0/0/1", name, load_done, load_ready, cpu_rst_n, load_busy);
    end
    cyc();
    checks++;
    if (load_done !== 1'b0 || load_busy !== 1'b0 || cpu_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL %s run: done=%b busy=%b cpu_rst_n=%b expected 0/0/1", name, load_done, load_busy, cpu_rst_n);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0);
    end
    checks++;
    if (mask_err !== 0) begin
      fails++;
      $display("FAIL %s masking: got %0d violations expected 0", name, mask_err);
    end
    for (int w = 0; w < nwords; w++) model_mem[w] = img[w];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    checks++;
    if (load_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0 || cpu_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL reset: ready=%b busy=%b done=%b cpu_rst_n=%b expected 0/0/0/1", load_ready, load_busy, load_done, cpu_rst_n);
    end
  endtask

  task automatic test_basic();
    img = '{16'h1234, 16'h5678, 16'h9ABC};
    run_load(3, 0, 1'b0, "basic");
    check_read(16'h0001, "basic_read1");
    for (int a = 0; a < 3; a++) check_read(16'(a), "basic_mem");
  endtask

  task automatic test_backpressure();
    for (int a = 0; a < 3; a++) model_mem[a] = 16'hxxxx;
    img = '{16'h1234, 16'h5678, 16'h9ABC};
    run_load(3, 5, 1'b1, "backpressure");
    for (int a = 0; a < 3; a++) check_read(16'(a), "bp_mem");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      int n;
      n = int'($urandom_range(12, 1));
      img.delete();
      for (int w = 0; w < n; w++) img.push_back(16'($urandom));
      run_load(n, 2, 1'b1, "random_load");
      for (int a = 0; a < n; a++) check_read(16'(a), "random_mem");
    end
  endtask

  task automatic test_full_depth();
    img.delete();
    for (int w = 0; w < 1024; w++) img.push_back(16'(w));
    run_load(0, 0, 1'b0, "full_depth");
    check_read(16'h03FF, "full_last");
    check_read(16'h0401, "full_wrap");
    check_read(16'hFC00, "full_wrap_hi");
    for (int a = 0; a < 1024; a += 37) check_read(16'(a), "full_mem");
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] w0;
    w0 = 16'($urandom);
    mask_err = 0;
    load_start = 1'b1;
    load_len = 10'd4;
    cyc();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_byte = (i == 0) ? w0[7:0] : (i == 1) ? w0[15:8] : 8'hA5;
      cyc();
    end
    load_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++;
    if (load_ready !== 1'b0 || load_busy !== 1'b0 || cpu_rst_n !== 1'b1 || load_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: ready=%b busy=%b cpu_rst_n=%b done=%b expected 0/0/1/0", load_ready, load_busy, cpu_rst_n, load_done);
    end
    checks++;
    if (mask_err !== 0) begin
      fails++;
      $display("FAIL reset_mid masking: got %0d violations expected 0", mask_err);
    end
    model_mem[0] = w0;
    check_read(16'h0000, "reset_mid_word0");
    check_read(16'h0001, "reset_mid_word1_kept");
  endtask

  task automatic test_idle_bytes();
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_byte = 8'($urandom);
      cyc();
      checks++;
      if (load_ready !== 1'b0 || load_busy !== 1'b0) begin
        fails++;
        $display("FAIL idle: ready=%b busy=%b expected 0/0", load_ready, load_busy);
      end
    end
    load_valid = 1'b0;
    for (int a = 0; a < 4; a++) check_read(16'(a), "idle_mem");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_full_depth();
    test_reset_mid_load();
    test_idle_bytes();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
